// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter for performance debug.
module pipe_stage_elastic #(
   parameter int unsigned DATA_W        = 32,
   parameter bit          ZERO_ON_FLUSH = 1'b1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   // Encoding equals the entry count, so occupancy is the state register itself.
   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StTwo   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              in_fire, out_fire;

   assign in_ready  = (state_q != StTwo);
   assign out_valid = (state_q != StEmpty);
   assign occupancy = state_q;
   assign out_data  = main_q;
   assign stall_cnt = stall_cnt_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Flush wins over any handshake; an accepted beat this cycle is dropped.
         state_d = StEmpty;
         if (ZERO_ON_FLUSH) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d = StOne;
                  main_d  = in_data;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = StTwo;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_fire) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StEmpty;
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: two instances share stimulus, one zeroing on flush
// with a 2-bit stall counter, one keeping payload on flush with a 16-bit counter.
module tb_pipe_stage_elastic;

   logic       clk = 1'b0;
   logic       rst, flush, in_valid, out_ready, stall_clr;
   logic [7:0] in_data;

   logic       z_in_ready, z_out_valid;
   logic [7:0] z_out_data;
   logic [1:0] z_occ;
   logic [1:0] z_cnt;
   logic       k_in_ready, k_out_valid;
   logic [7:0] k_out_data;
   logic [1:0] k_occ;
   logic [15:0] k_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(8), .ZERO_ON_FLUSH(1'b1), .CNT_W(2)) u_z (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
      .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
      .occupancy(z_occ), .stall_cnt(z_cnt), .stall_clr(stall_clr)
   );

   pipe_stage_elastic #(.DATA_W(8), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)) u_k (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(k_in_ready), .in_data(in_data),
      .out_valid(k_out_valid), .out_ready(out_ready), .out_data(k_out_data),
      .occupancy(k_occ), .stall_cnt(k_cnt), .stall_clr(stall_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      int         pushed, cyc;
      logic       iv, ordy, fi, fo;
      logic [7:0] d;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      stall_clr = 1'b0; in_data = 8'h00;
      step(); step();
      chk("rst_in_ready", z_in_ready, 1);
      chk("rst_out_valid", z_out_valid, 0);
      chk("rst_occ", z_occ, 0);
      rst = 1'b0;

      // Fill both entries, then reset asynchronously between edges.
      in_valid = 1'b1; in_data = 8'h5A; step();
      in_data = 8'h5B; step();
      in_valid = 1'b0;
      chk("fill_occ", z_occ, 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", z_in_ready, 1);
      chk("arst_out_valid", z_out_valid, 0);
      chk("arst_occ", z_occ, 0);
      chk("arst_data_z", z_out_data, 0);
      chk("arst_data_k", k_out_data, 0);
      chk("arst_cnt_k", k_cnt, 0);
      #1 rst = 1'b0;

      // Streaming at full rate.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11; step();
      chk("s1_data", z_out_data, 8'h11); chk("s1_occ", z_occ, 1);
      in_data = 8'h22; step();
      chk("s2_data", z_out_data, 8'h22); chk("s2_occ", z_occ, 1);
      in_data = 8'h33; step();
      chk("s3_data", z_out_data, 8'h33); chk("s3_occ", z_occ, 1);
      in_valid = 1'b0; step();
      chk("s_drain_valid", z_out_valid, 0);

      // Backpressure into the skid register.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1; step();
      chk("bp1_occ", z_occ, 1); chk("bp1_data", z_out_data, 8'hA1);
      in_data = 8'hA2; step();
      chk("bp2_occ", z_occ, 2); chk("bp2_in_ready", z_in_ready, 0);
      chk("bp2_data", z_out_data, 8'hA1);
      in_data = 8'hA3; step();
      chk("bp3_occ", z_occ, 2); chk("bp3_data", z_out_data, 8'hA1);
      out_ready = 1'b1; step();
      chk("bp4_data", z_out_data, 8'hA2); chk("bp4_occ", z_occ, 1);
      step();
      chk("bp5_data", z_out_data, 8'hA3); chk("bp5_occ", z_occ, 1);
      in_valid = 1'b0; step();
      chk("bp6_occ", z_occ, 0);

      // Stall counter saturation and clear priority.
      stall_clr = 1'b1; step();
      chk("clr_z", z_cnt, 0); chk("clr_k", k_cnt, 0);
      stall_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1; step();
      chk("st0_z", z_cnt, 0);
      in_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("st_sat_z", z_cnt, (i > 3) ? 3 : i);
         chk("st_k", k_cnt, i);
      end
      stall_clr = 1'b1; step();
      chk("st_clr_z", z_cnt, 0); chk("st_clr_k", k_cnt, 0);
      stall_clr = 1'b0; step();
      chk("st_after_clr_z", z_cnt, 1);

      // Flush from TWO with a beat presented.
      out_ready = 1'b1; step();
      chk("pre_flush_occ", z_occ, 0);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1; step();
      in_data = 8'hA2; step();
      chk("pre_flush2_occ", z_occ, 2);
      flush = 1'b1; in_data = 8'hFF; step();
      chk("fl_occ_z", z_occ, 0); chk("fl_valid_z", z_out_valid, 0);
      chk("fl_data_z", z_out_data, 0);
      chk("fl_occ_k", k_occ, 0); chk("fl_valid_k", k_out_valid, 0);
      chk("fl_data_k", k_out_data, 8'hA1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
      chk("fl_no_ff", z_out_valid, 0);

      // Flush from ONE: the concurrently accepted beat is dropped.
      in_valid = 1'b1; in_data = 8'h77; step();
      flush = 1'b1; in_data = 8'h88; step();
      chk("fl1_occ", z_occ, 0);
      flush = 1'b0; in_valid = 1'b0; step();
      chk("fl1_valid", z_out_valid, 0);

      // Random traffic checked against a 2-deep FIFO model.
      pushed = 0; cyc = 0;
      while ((pushed < 100 || q.size() != 0) && cyc < 2000) begin
         iv   = (pushed < 100) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 1) == 1) || (pushed >= 100);
         d    = 8'($urandom);
         in_valid = iv; out_ready = ordy; in_data = d;
         chk("rnd_occ", z_occ, q.size());
         chk("rnd_in_ready", z_in_ready, (q.size() != 2));
         chk("rnd_out_valid", z_out_valid, (q.size() != 0));
         if (q.size() != 0) chk("rnd_data", z_out_data, q[0]);
         fi = iv && (q.size() < 2);
         fo = ordy && (q.size() != 0);
         step();
         cyc++;
         if (fo) void'(q.pop_front());
         if (fi) begin
            q.push_back(d);
            pushed++;
         end
      end
      in_valid = 1'b0;
      chk("rnd_bound", (cyc < 2000), 1);
      chk("rnd_end_occ", z_occ, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
